uc_tile_ctrl: RTL and testbench
===============================

// Module: uc_tile_ctrl
// PURPOSE
//  Host-side run-control tile for the 8-bit uC core: generalised successor of the first uC tile wrapper.
//  Replaces the host-driven core clock with a core clock-enable (core_ce) gated by a HALT/RUN/STEP/RUN-TO-BREAK FSM.
//  Adds a 4-phase flash-load handshake, a PC breakpoint, N parametrised output ports and a saturating core-cycle counter.
//  Sits between the host register bank (csr_in/data_reg_*) and the core.
// PARAMETERS
//  REG_WIDTH      32  host data register width (>=32)
//  CSR_IN_WIDTH   16  host control word width (>=6)
//  CSR_OUT_WIDTH  16  host status word width (>=7)
//  PC_WIDTH       12  core program-counter width (<=16)
//  N_OUT_PORTS    2   number of core output ports (>=1)
//  PORT_WIDTH     8   width of each output port
//  CYC_WIDTH      16  core-cycle counter width (<=16)
// PORTS
//  clk          in   1                        single clock, all logic rising-edge
//  arst_n       in   1                        asynchronous active-low reset
//  csr_in       in   CSR_IN_WIDTH             [1:0] mode 00 HALT/01 RUN/10 STEP/11 RTB; [2] step_req; [3] brk_clr; [4] flash_valid; [5] cyc_clr
//  data_reg_a   in   REG_WIDTH                [PC_WIDTH-1:0] breakpoint address
//  data_reg_b   in   REG_WIDTH                [15:0] flash word from host
//  data_reg_c   out  REG_WIDTH                {0, cyc_cnt} in [31:16], zero-extended core_pc in [15:0]
//  csr_out      out  CSR_OUT_WIDTH            [0] running [1] brk_hit [2] flash_ack [3] core_boot [4] cyc_sat [6:5] state; rest 0
//  csr_in_re    out  1                        tied 1
//  csr_out_we   out  1                        tied 1
//  core_ce      out  1                        core clock enable (combinational decode, see BEHAVIOUR)
//  core_pc      in   PC_WIDTH                 core PC
//  core_pc_valid in  1                        core_pc holds a fetch address this cycle
//  core_boot    in   1                        core in bootstrap (flash-load) mode
//  flash_data   out  16                       captured flash word, held until next accept
//  flash_ready  out  1                        1-cycle pulse with the flash word
//  core_out_we  in   1                        core writes an output port
//  core_out_idx in   max(1,clog2(N_OUT_PORTS)) target port
//  core_out_data in  PORT_WIDTH               port write data
//  out_gpio     out  N_OUT_PORTS*PORT_WIDTH   {port[N-1],...,port[0]}
// BEHAVIOUR
//  Reset: state=HALT(00), all registers and outputs 0, except the tied-1 csr_in_re/csr_out_we.
//  step_req and flash_valid are edge-detected against a registered copy of csr_in[2] and csr_in[4] (reset 0).
//  States: HALT=00, RUN=01, BRK=10, FL_ACK=11.
//   HALT: core_ce=0 except as below. Checks in priority order:
//    1) flash_valid rise & core_boot: capture data_reg_b[15:0] into flash_data; next cycle flash_ready=1 and core_ce=1 for exactly one cycle; -> FL_ACK.
//    2) else mode RUN, or mode RTB with brk_hit=0: -> RUN.
//    3) else mode STEP & step_req rise: core_ce=1 for exactly the next cycle; stay HALT.
//   RUN: core_ce = ~bp_match, where bp_match = (mode==RTB) & core_pc_valid & (core_pc==bp).
//    bp_match: brk_hit<=1, -> BRK; the instruction at bp is NOT executed.
//    mode HALT or STEP: -> HALT, with core_ce=0 from that cycle.
//   BRK: core_ce=0. brk_clr=1: brk_hit<=0, -> HALT. Mode changes are ignored.
//   FL_ACK: flash_ack=1, core_ce=0. flash_valid low: -> HALT. The host must drop flash_valid before the next word (4-phase handshake).
//  running = (state==RUN).
//  Output ports: on core_out_we & core_ce, port[core_out_idx] <= core_out_data. idx >= N_OUT_PORTS is ignored. Ports hold while halted.
//  Cycle counter:
//   - cyc_clr=1: counter <= 0 and cyc_sat <= 0 (clear has priority).
//   - else core_ce=1: counter increments, saturating at all-ones; cyc_sat=1 while saturated.
//  Async reset mid-handshake or mid-run aborts immediately. After reset the core sees core_ce=0 and flash_ready=0.
// TESTING
//  1 reset, mode RUN, 10 cycles -> core_ce=1 throughout; cyc_cnt=10; csr_out[0]=1, [6:5]=01
//  2 mode STEP, pulse step_req 3x (held 4 cycles each) -> exactly 3 single-cycle core_ce pulses; cyc_cnt=3
//  3 mode RTB, bp=0x005, core_pc counts 0..; pc_valid=1 -> core_ce low in the cycle pc==5; brk_hit=1; state BRK; RUN ignored until brk_clr
//  4 core_boot=1, HALT, data_reg_b=0xA55A, raise flash_valid -> flash_data=0xA55A, 1-cycle flash_ready+core_ce; flash_ack=1 until valid drops
//  5 N_OUT_PORTS=3: write idx2=0x7E, idx3=0xFF with core_ce=1 -> out_gpio=0x7E0000; idx3 ignored; write with core_ce=0 ignored
//  6 CYC_WIDTH=4, RUN 20 cycles -> cyc_cnt=0xF, cyc_sat=1; cyc_clr -> 0; arst_n low mid-FL_ACK -> HALT, all outputs 0

Source files
------------

// File: rtl/uc_tile_ctrl.sv
// Run-control tile for the 8-bit uC core: gates the core clock enable through a
// HALT/RUN/STEP/RUN-TO-BREAK FSM, handles flash loading, output ports and a cycle counter.
module uc_tile_ctrl #(
  parameter int REG_WIDTH     = 32,
  parameter int CSR_IN_WIDTH  = 16,
  parameter int CSR_OUT_WIDTH = 16,
  parameter int PC_WIDTH      = 12,
  parameter int N_OUT_PORTS   = 2,
  parameter int PORT_WIDTH    = 8,
  parameter int CYC_WIDTH     = 16,
  localparam int IDX_WIDTH    = (N_OUT_PORTS > 1) ? $clog2(N_OUT_PORTS) : 1
) (
  input  logic                              clk,
  input  logic                              arst_n,
  input  logic [CSR_IN_WIDTH-1:0]           csr_in,
  input  logic [REG_WIDTH-1:0]              data_reg_a,
  input  logic [REG_WIDTH-1:0]              data_reg_b,
  output logic [REG_WIDTH-1:0]              data_reg_c,
  output logic [CSR_OUT_WIDTH-1:0]          csr_out,
  output logic                              csr_in_re,
  output logic                              csr_out_we,
  output logic                              core_ce,
  input  logic [PC_WIDTH-1:0]               core_pc,
  input  logic                              core_pc_valid,
  input  logic                              core_boot,
  output logic [15:0]                       flash_data,
  output logic                              flash_ready,
  input  logic                              core_out_we,
  input  logic [IDX_WIDTH-1:0]              core_out_idx,
  input  logic [PORT_WIDTH-1:0]             core_out_data,
  output logic [N_OUT_PORTS*PORT_WIDTH-1:0] out_gpio
);

  typedef enum logic [1:0] {
    ST_HALT   = 2'b00,
    ST_RUN    = 2'b01,
    ST_BRK    = 2'b10,
    ST_FL_ACK = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_RTB  = 2'b11
  } mode_t;

  state_t                 state_q, state_d;
  mode_t                  mode;
  logic                   step_req, brk_clr, flash_valid, cyc_clr;
  logic                   step_q, flash_q, step_rise, flash_rise;
  logic                   bp_match;
  logic                   flash_capture, step_start, brk_set, brk_release;
  logic                   step_pulse, flash_pulse;
  logic                   brk_hit, running, flash_ack;
  logic                   boot_q;
  logic [PC_WIDTH-1:0]    pc_q;
  logic [CYC_WIDTH-1:0]   cyc_cnt;
  logic                   cyc_sat;
  logic [PORT_WIDTH-1:0]  port_q [N_OUT_PORTS];
  logic                   unused_bits;

  assign mode        = mode_t'(csr_in[1:0]);
  assign step_req    = csr_in[2];
  assign brk_clr     = csr_in[3];
  assign flash_valid = csr_in[4];
  assign cyc_clr     = csr_in[5];

  // Only the low control/data bits are meaningful; the rest are reserved.
  assign unused_bits = ^{csr_in, data_reg_a, data_reg_b};

  assign step_rise  = step_req & ~step_q;
  assign flash_rise = flash_valid & ~flash_q;
  assign bp_match   = (mode == MODE_RTB) & core_pc_valid &
                      (core_pc == data_reg_a[PC_WIDTH-1:0]);
  assign cyc_sat    = &cyc_cnt;

  assign csr_in_re   = 1'b1;
  assign csr_out_we  = 1'b1;
  assign flash_ready = flash_pulse;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      step_q  <= 1'b0;
      flash_q <= 1'b0;
      boot_q  <= 1'b0;
      pc_q    <= '0;
    end else begin
      step_q  <= step_req;
      flash_q <= flash_valid;
      boot_q  <= core_boot;
      pc_q    <= core_pc;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= ST_HALT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    flash_capture = 1'b0;
    step_start    = 1'b0;
    brk_set       = 1'b0;
    brk_release   = 1'b0;
    case (state_q)
      ST_HALT: begin
        if (flash_rise && core_boot) begin
          flash_capture = 1'b1;
          state_d       = ST_FL_ACK;
        end else if (mode == MODE_RUN || (mode == MODE_RTB && !brk_hit)) begin
          state_d = ST_RUN;
        end else if (mode == MODE_STEP && step_rise) begin
          step_start = 1'b1;
        end
      end
      ST_RUN: begin
        if (bp_match) begin
          brk_set = 1'b1;
          state_d = ST_BRK;
        end else if (mode == MODE_HALT || mode == MODE_STEP) begin
          state_d = ST_HALT;
        end
      end
      // Only an explicit clear leaves a break; mode changes are deliberately ignored.
      ST_BRK: begin
        if (brk_clr) begin
          brk_release = 1'b1;
          state_d     = ST_HALT;
        end
      end
      ST_FL_ACK: begin
        if (!flash_valid) state_d = ST_HALT;
      end
      default: state_d = ST_HALT;
    endcase
  end

  // The breakpoint instruction must not execute, so the enable drops in the matching cycle.
  always_comb begin
    core_ce   = step_pulse | flash_pulse;
    running   = 1'b0;
    flash_ack = 1'b0;
    case (state_q)
      ST_RUN: begin
        running = 1'b1;
        if ((mode == MODE_RUN || mode == MODE_RTB) && !bp_match) core_ce = 1'b1;
      end
      ST_FL_ACK: flash_ack = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      step_pulse  <= 1'b0;
      flash_pulse <= 1'b0;
      flash_data  <= '0;
      brk_hit     <= 1'b0;
    end else begin
      step_pulse  <= step_start;
      flash_pulse <= flash_capture;
      if (flash_capture) flash_data <= data_reg_b[15:0];
      if (brk_set)          brk_hit <= 1'b1;
      else if (brk_release) brk_hit <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)              cyc_cnt <= '0;
    else if (cyc_clr)         cyc_cnt <= '0;
    else if (core_ce && !cyc_sat) cyc_cnt <= cyc_cnt + CYC_WIDTH'(1);
  end

  // Writes to indices beyond the implemented ports match no entry and are dropped.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int p = 0; p < N_OUT_PORTS; p++) port_q[p] <= '0;
    end else if (core_out_we && core_ce) begin
      for (int p = 0; p < N_OUT_PORTS; p++) begin
        if (core_out_idx == IDX_WIDTH'(p)) port_q[p] <= core_out_data;
      end
    end
  end

  always_comb begin
    out_gpio = '0;
    for (int p = 0; p < N_OUT_PORTS; p++) begin
      out_gpio[p*PORT_WIDTH +: PORT_WIDTH] = port_q[p];
    end
  end

  always_comb begin
    data_reg_c                   = '0;
    data_reg_c[16 +: CYC_WIDTH]  = cyc_cnt;
    data_reg_c[PC_WIDTH-1:0]     = pc_q;
  end

  always_comb begin
    csr_out      = '0;
    csr_out[0]   = running;
    csr_out[1]   = brk_hit;
    csr_out[2]   = flash_ack;
    csr_out[3]   = boot_q;
    csr_out[4]   = cyc_sat;
    csr_out[6:5] = state_q;
  end

endmodule

// File: tb/tb_uc_tile_ctrl.sv
// Bench for uc_tile_ctrl: directed scenarios plus randomized traffic, all checked
// every cycle against a spec-level run-control model.
module tb_uc_tile_ctrl;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [1:0]  mode;
  logic        step_req, brk_clr, flash_valid, cyc_clr;
  logic [9:0]  csr_hi;
  logic [15:0] csr_in;
  logic [31:0] data_reg_a, data_reg_b, data_reg_c;
  logic [15:0] csr_out;
  logic        csr_in_re, csr_out_we, core_ce;
  logic [11:0] core_pc;
  logic        core_pc_valid, core_boot;
  logic [15:0] flash_data;
  logic        flash_ready;
  logic        core_out_we;
  logic [1:0]  core_out_idx;
  logic [7:0]  core_out_data;
  logic [23:0] out_gpio;

  int checks   = 0;
  int failures = 0;

  assign csr_in = {csr_hi, cyc_clr, flash_valid, brk_clr, step_req, mode};

  always #5 clk = ~clk;

  uc_tile_ctrl #(
    .REG_WIDTH(32), .CSR_IN_WIDTH(16), .CSR_OUT_WIDTH(16), .PC_WIDTH(12),
    .N_OUT_PORTS(3), .PORT_WIDTH(8), .CYC_WIDTH(4)
  ) dut (
    .clk(clk), .arst_n(arst_n), .csr_in(csr_in),
    .data_reg_a(data_reg_a), .data_reg_b(data_reg_b), .data_reg_c(data_reg_c),
    .csr_out(csr_out), .csr_in_re(csr_in_re), .csr_out_we(csr_out_we),
    .core_ce(core_ce), .core_pc(core_pc), .core_pc_valid(core_pc_valid),
    .core_boot(core_boot), .flash_data(flash_data), .flash_ready(flash_ready),
    .core_out_we(core_out_we), .core_out_idx(core_out_idx),
    .core_out_data(core_out_data), .out_gpio(out_gpio)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, actual, expected, $time);
    end
  endtask

  // Model state: phase numbers are the host-visible status codes
  // (0 halted, 1 running, 2 stopped at breakpoint, 3 acknowledging flash word).
  int         m_phase;
  bit         m_brk, m_grant, m_ready, m_prev_step, m_prev_fv, m_boot_seen;
  int         m_cycles;
  int         m_pc_seen;
  logic [15:0] m_word;
  logic [7:0]  m_port [3];

  always @(negedge clk) begin : compare
    bit          exp_ce, at_bp, wants_run;
    logic [15:0] exp_csr;
    logic [31:0] exp_drc, exp_gpio;
    if (!arst_n) begin
      m_phase = 0; m_brk = 0; m_grant = 0; m_ready = 0;
      m_prev_step = 0; m_prev_fv = 0; m_boot_seen = 0;
      m_cycles = 0; m_pc_seen = 0; m_word = '0;
      for (int i = 0; i < 3; i++) m_port[i] = '0;
      checkOutput("rst_core_ce", core_ce, 0);
      checkOutput("rst_flash_ready", flash_ready, 0);
      checkOutput("rst_flash_data", flash_data, 0);
      checkOutput("rst_csr_out", csr_out, 0);
      checkOutput("rst_data_reg_c", data_reg_c, 0);
      checkOutput("rst_out_gpio", out_gpio, 0);
      checkOutput("rst_csr_in_re", csr_in_re, 1);
      checkOutput("rst_csr_out_we", csr_out_we, 1);
    end else begin
      at_bp     = (mode == 2'd3) && core_pc_valid && (core_pc == data_reg_a[11:0]);
      wants_run = (mode == 2'd1) || (mode == 2'd3);
      exp_ce    = m_grant || (m_phase == 1 && wants_run && !at_bp);
      exp_csr      = '0;
      exp_csr[0]   = (m_phase == 1);
      exp_csr[1]   = m_brk;
      exp_csr[2]   = (m_phase == 3);
      exp_csr[3]   = m_boot_seen;
      exp_csr[4]   = (m_cycles == 15);
      exp_csr[6:5] = m_phase[1:0];
      exp_drc  = (32'(m_cycles) << 16) | 32'(m_pc_seen);
      exp_gpio = {8'h00, m_port[2], m_port[1], m_port[0]};
      checkOutput("core_ce", core_ce, exp_ce);
      checkOutput("flash_ready", flash_ready, m_ready);
      checkOutput("flash_data", flash_data, m_word);
      checkOutput("csr_out", csr_out, exp_csr);
      checkOutput("data_reg_c", data_reg_c, exp_drc);
      checkOutput("out_gpio", out_gpio, exp_gpio);
      checkOutput("csr_in_re", csr_in_re, 1);
      checkOutput("csr_out_we", csr_out_we, 1);

      // Advance the model by one clock.
      if (exp_ce && core_out_we && core_out_idx < 2'd3) m_port[core_out_idx] = core_out_data;
      if (cyc_clr) m_cycles = 0;
      else if (exp_ce && m_cycles < 15) m_cycles++;
      m_grant = 0;
      m_ready = 0;
      if (m_phase == 0) begin
        if (flash_valid && !m_prev_fv && core_boot) begin
          m_word = data_reg_b[15:0]; m_grant = 1; m_ready = 1; m_phase = 3;
        end else if (mode == 2'd1 || (mode == 2'd3 && !m_brk)) begin
          m_phase = 1;
        end else if (mode == 2'd2 && step_req && !m_prev_step) begin
          m_grant = 1;
        end
      end else if (m_phase == 1) begin
        if (at_bp) begin m_brk = 1; m_phase = 2; end
        else if (!wants_run) m_phase = 0;
      end else if (m_phase == 2) begin
        if (brk_clr) begin m_brk = 0; m_phase = 0; end
      end else begin
        if (!flash_valid) m_phase = 0;
      end
      m_prev_step = step_req;
      m_prev_fv   = flash_valid;
      m_boot_seen = core_boot;
      m_pc_seen   = int'(core_pc);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus();
    if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
    step_req      = 1'($urandom_range(0, 1));
    brk_clr       = ($urandom_range(0, 7) == 0);
    flash_valid   = 1'($urandom_range(0, 1));
    cyc_clr       = ($urandom_range(0, 15) == 0);
    csr_hi        = 10'($urandom);
    core_boot     = 1'($urandom_range(0, 1));
    data_reg_a    = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 7));
    data_reg_b    = $urandom;
    core_pc       = 12'($urandom_range(0, 7));
    core_pc_valid = 1'($urandom_range(0, 1));
    core_out_we   = 1'($urandom_range(0, 1));
    core_out_idx  = 2'($urandom_range(0, 3));
    core_out_data = 8'($urandom);
    arst_n        = ($urandom_range(0, 99) != 0);
  endtask

  initial begin
    int pulses;
    arst_n = 1'b0; mode = 2'd0; step_req = 0; brk_clr = 0; flash_valid = 0; cyc_clr = 0;
    csr_hi = '0; data_reg_a = '0; data_reg_b = '0; core_pc = '0; core_pc_valid = 0;
    core_boot = 0; core_out_we = 0; core_out_idx = '0; core_out_data = '0;
    wait_cycles(2);
    arst_n = 1'b1;
    checkOutput("reset_csr_out", csr_out, 0);
    checkOutput("reset_core_ce", core_ce, 0);

    $display("[TB] free run");
    mode = 2'd1;
    wait_cycles(1);
    for (int i = 0; i < 10; i++) begin
      checkOutput("t1_core_ce", core_ce, 1);
      wait_cycles(1);
    end
    checkOutput("t1_cyc_cnt", data_reg_c[19:16], 10);
    checkOutput("t1_running", csr_out[0], 1);
    checkOutput("t1_state", csr_out[6:5], 1);
    mode = 2'd0;
    wait_cycles(1);

    $display("[TB] single step");
    cyc_clr = 1; wait_cycles(1); cyc_clr = 0;
    mode = 2'd2;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      step_req = 1;
      for (int j = 0; j < 4; j++) begin wait_cycles(1); pulses += int'(core_ce); end
      step_req = 0;
      for (int j = 0; j < 4; j++) begin wait_cycles(1); pulses += int'(core_ce); end
    end
    checkOutput("t2_pulses", pulses, 3);
    checkOutput("t2_cyc_cnt", data_reg_c[19:16], 3);
    mode = 2'd0;
    wait_cycles(1);

    $display("[TB] run to breakpoint");
    data_reg_a = 32'h005; core_pc_valid = 1; core_pc = '0; mode = 2'd3;
    wait_cycles(1);
    for (int pc = 0; pc <= 5; pc++) begin
      core_pc = 12'(pc);
      #1;
      checkOutput("t3_core_ce", core_ce, (pc != 5));
      wait_cycles(1);
    end
    checkOutput("t3_brk_hit", csr_out[1], 1);
    checkOutput("t3_state_brk", csr_out[6:5], 2);
    mode = 2'd1;
    wait_cycles(3);
    checkOutput("t3_run_ignored", csr_out[6:5], 2);
    mode = 2'd0; brk_clr = 1;
    wait_cycles(1);
    checkOutput("t3_brk_cleared", csr_out[1], 0);
    checkOutput("t3_state_halt", csr_out[6:5], 0);
    brk_clr = 0; core_pc_valid = 0;

    $display("[TB] flash handshake");
    core_boot = 1; data_reg_b = 32'h0000_A55A; flash_valid = 1;
    wait_cycles(1);
    checkOutput("t4_flash_ready", flash_ready, 1);
    checkOutput("t4_grant_ce", core_ce, 1);
    checkOutput("t4_flash_data", flash_data, 16'hA55A);
    checkOutput("t4_flash_ack", csr_out[2], 1);
    wait_cycles(1);
    checkOutput("t4_ready_drop", flash_ready, 0);
    checkOutput("t4_ce_drop", core_ce, 0);
    wait_cycles(2);
    checkOutput("t4_ack_held", csr_out[2], 1);
    flash_valid = 0;
    wait_cycles(1);
    checkOutput("t4_ack_release", csr_out[2], 0);
    core_boot = 0;

    $display("[TB] output ports");
    mode = 2'd1;
    wait_cycles(1);
    core_out_we = 1; core_out_idx = 2'd2; core_out_data = 8'h7E;
    wait_cycles(1);
    core_out_idx = 2'd3; core_out_data = 8'hFF;
    wait_cycles(1);
    core_out_we = 0;
    checkOutput("t5_gpio", out_gpio, 24'h7E0000);
    mode = 2'd0;
    #1;
    checkOutput("t5_ce_off", core_ce, 0);
    core_out_we = 1; core_out_idx = 2'd0; core_out_data = 8'h55;
    wait_cycles(2);
    core_out_we = 0;
    checkOutput("t5_gpio_hold", out_gpio, 24'h7E0000);

    $display("[TB] counter saturation and reset abort");
    cyc_clr = 1; wait_cycles(1); cyc_clr = 0;
    mode = 2'd1;
    wait_cycles(21);
    checkOutput("t6_cyc_max", data_reg_c[19:16], 4'hF);
    checkOutput("t6_cyc_sat", csr_out[4], 1);
    cyc_clr = 1;
    wait_cycles(1);
    checkOutput("t6_cyc_clr", data_reg_c[19:16], 0);
    checkOutput("t6_sat_clr", csr_out[4], 0);
    cyc_clr = 0; mode = 2'd0;
    wait_cycles(1);
    core_boot = 1; data_reg_b = 32'h0000_1234; flash_valid = 1;
    wait_cycles(2);
    checkOutput("t6_in_fl_ack", csr_out[6:5], 3);
    arst_n = 0;
    #1;
    checkOutput("t6_rst_csr_out", csr_out, 0);
    checkOutput("t6_rst_drc", data_reg_c, 0);
    checkOutput("t6_rst_gpio", out_gpio, 0);
    checkOutput("t6_rst_fdata", flash_data, 0);
    checkOutput("t6_rst_fready", flash_ready, 0);
    checkOutput("t6_rst_ce", core_ce, 0);
    wait_cycles(1);
    flash_valid = 0; core_boot = 0;
    arst_n = 1;
    wait_cycles(1);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 600; n++) begin
      applyStimulus();
      wait_cycles(1);
    end
    arst_n = 1;
    wait_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
